// File: rtl/mcpu5_sequencer_if.sv
// Host and core-side signal bundle for the MCPU5plus sequencer.
// master = host/core side, slave = sequencer.
interface mcpu5_sequencer_if #(
  parameter int PROG_AW = 6,
  parameter int CNT_W   = 16
);
  logic               load_valid;
  logic [PROG_AW-1:0] load_addr;
  logic [5:0]         load_data;
  logic               load_ready;
  logic               start;
  logic               stop;
  logic               step;
  logic               bp_en;
  logic [7:0]         bp_addr;
  logic               cpu_clk;
  logic               cpu_rst;
  logic [5:0]         cpu_inst;
  logic [7:0]         cpu_data;
  logic [7:0]         out_data;
  logic               out_valid;
  logic               running;
  logic               halted;
  logic [CNT_W-1:0]   cycle_count;

  modport master (
    output load_valid, load_addr, load_data, start, stop, step, bp_en, bp_addr, cpu_data,
    input  load_ready, cpu_clk, cpu_rst, cpu_inst, out_data, out_valid, running, halted,
           cycle_count
  );

  modport slave (
    input  load_valid, load_addr, load_data, start, stop, step, bp_en, bp_addr, cpu_data,
    output load_ready, cpu_clk, cpu_rst, cpu_inst, out_data, out_valid, running, halted,
           cycle_count
  );
endinterface

// File: rtl/mcpu5_sequencer.sv
// Sequencer for one MCPU5plus core: half-rate core clock/reset, local program RAM,
// OUT capture and host run/stop/step/breakpoint control.
module mcpu5_sequencer #(
  parameter int PROG_AW = 6,
  parameter int CNT_W   = 16
) (
  input logic              clk,
  input logic              rst,
  mcpu5_sequencer_if.slave bus
);
  // state | meaning
  // IDLE  | core held in reset, program loadable
  // RSTA  | core clock low, reset asserted
  // RSTB  | core clock high, rising edge resets the core
  // FETCH | core clock high, cpu_data is PC, instruction looked up
  // EXEC  | core clock low, cpu_data is accu, cpu_inst held for the next rising edge
  // HALT  | core clock held high, core state frozen, program loadable
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] RSTA  = 3'd1;
  localparam logic [2:0] RSTB  = 3'd2;
  localparam logic [2:0] FETCH = 3'd3;
  localparam logic [2:0] EXEC  = 3'd4;
  localparam logic [2:0] HALT  = 3'd5;

  localparam logic [5:0] OP_OUT = 6'b111011;

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic       stop_pend;
  logic       step_pend;
  logic       step_done;
  logic       bp_skip;
  logic       bp_hit;
  logic [5:0] prog_mem [2**PROG_AW];

  assign bp_hit = bus.bp_en && (bus.cpu_data == bus.bp_addr) && !bp_skip;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RSTA;
      RSTA:    state_nxt = RSTB;
      RSTB:    state_nxt = FETCH;
      FETCH:   state_nxt = (stop_pend || bp_hit || (step_pend && step_done)) ? HALT : EXEC;
      EXEC:    state_nxt = FETCH;
      HALT:    if (bus.start || bus.step) state_nxt = FETCH;
      default: state_nxt = IDLE;
    endcase
  end

  // load_ready is only high in IDLE/HALT, so a write never races the fetch read
  always_ff @(posedge clk) begin
    if (bus.load_valid && bus.load_ready) prog_mem[bus.load_addr] <= bus.load_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state           <= IDLE;
      bus.cpu_clk     <= 1'b0;
      bus.cpu_rst     <= 1'b1;
      bus.cpu_inst    <= '0;
      bus.out_data    <= '0;
      bus.out_valid   <= 1'b0;
      bus.cycle_count <= '0;
      bus.load_ready  <= 1'b1;
      bus.running     <= 1'b0;
      bus.halted      <= 1'b0;
      stop_pend       <= 1'b0;
      step_pend       <= 1'b0;
      step_done       <= 1'b0;
      bp_skip         <= 1'b0;
    end else begin
      state          <= state_nxt;
      bus.cpu_clk    <= (state_nxt == RSTB) || (state_nxt == FETCH) || (state_nxt == HALT);
      bus.cpu_rst    <= (state_nxt == IDLE) || (state_nxt == RSTA) || (state_nxt == RSTB);
      bus.load_ready <= (state_nxt == IDLE) || (state_nxt == HALT);
      bus.running    <= (state_nxt == FETCH) || (state_nxt == EXEC);
      bus.halted     <= (state_nxt == HALT);
      bus.out_valid  <= 1'b0;

      if (bus.stop && ((state == FETCH) || (state == EXEC))) stop_pend <= 1'b1;

      case (state)
        IDLE: if (bus.start) bus.cycle_count <= '0;
        RSTA: bus.cycle_count <= '0;
        FETCH: begin
          // any halt satisfies a pending stop or step
          if (state_nxt == HALT) begin
            stop_pend <= 1'b0;
            step_pend <= 1'b0;
            step_done <= 1'b0;
          end else begin
            bus.cpu_inst <= prog_mem[bus.cpu_data[PROG_AW-1:0]];
          end
        end
        EXEC: begin
          if (bus.cpu_inst == OP_OUT) begin
            bus.out_data  <= bus.cpu_data;
            bus.out_valid <= 1'b1;
          end
          if (bus.cycle_count != '1) bus.cycle_count <= bus.cycle_count + CNT_W'(1);
          bp_skip <= 1'b0;
          if (step_pend) step_done <= 1'b1;
        end
        HALT: begin
          if (bus.start) begin
            bp_skip   <= 1'b1;
            step_pend <= 1'b0;
            step_done <= 1'b0;
          end else if (bus.step) begin
            bp_skip   <= 1'b1;
            step_pend <= 1'b1;
            step_done <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mcpu5_sequencer.sv
// Directed bench for mcpu5_sequencer with a minimal MCPU5plus core model
// (LDI, OUT, relative branch) driving the multiplexed PC/accu bus.
module tb_mcpu5_sequencer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mcpu5_sequencer_if #(.PROG_AW(6), .CNT_W(4)) bus ();

  mcpu5_sequencer #(.PROG_AW(6), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // core model: 00iiii branch rel, 01iiii load immediate, others advance PC
  logic [7:0] core_pc;
  logic [7:0] core_accu;
  always @(posedge bus.cpu_clk) begin
    if (bus.cpu_rst) begin
      core_pc   <= 8'd0;
      core_accu <= 8'd0;
    end else begin
      case (bus.cpu_inst[5:4])
        2'b00:   core_pc <= core_pc + {{4{bus.cpu_inst[3]}}, bus.cpu_inst[3:0]};
        2'b01: begin
          core_accu <= {{4{bus.cpu_inst[3]}}, bus.cpu_inst[3:0]};
          core_pc   <= core_pc + 8'd1;
        end
        default: core_pc <= core_pc + 8'd1;
      endcase
    end
  end
  assign bus.cpu_data = bus.cpu_clk ? core_pc : core_accu;

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [5:0] a, input logic [5:0] d);
    bus.load_valid = 1'b1;
    bus.load_addr  = a;
    bus.load_data  = d;
    tick();
    bus.load_valid = 1'b0;
  endtask

  task automatic pulse_start;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic pulse_step;
    bus.step = 1'b1;
    tick();
    bus.step = 1'b0;
  endtask

  task automatic run_to_halt(input int max, output int ncyc, output int nout,
                             output logic [7:0] last);
    ncyc = 0;
    nout = 0;
    last = 8'h00;
    while (!bus.halted && ncyc < max) begin
      tick();
      ncyc++;
      if (bus.out_valid) begin
        nout++;
        last = bus.out_data;
      end
    end
    check("halt_reached", 32'(bus.halted), 1);
  endtask

  task automatic wait_out(input int max, output int ncyc);
    ncyc = 0;
    do begin
      tick();
      ncyc++;
    end while (!bus.out_valid && ncyc < max);
    check("out_seen", 32'(bus.out_valid), 1);
  endtask

  int n;
  int o;
  logic [7:0] last;
  int exp_clk, exp_rst, exp_run, exp_ov, exp_cnt, e, exp_inst;

  initial begin
    rst = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_addr  = '0;
    bus.load_data  = '0;
    bus.start      = 1'b0;
    bus.stop       = 1'b0;
    bus.step       = 1'b0;
    bus.bp_en      = 1'b0;
    bus.bp_addr    = 8'h00;
    tick();
    tick();
    check("rst_cpu_clk",   32'(bus.cpu_clk), 0);
    check("rst_cpu_rst",   32'(bus.cpu_rst), 1);
    check("rst_cpu_inst",  32'(bus.cpu_inst), 0);
    check("rst_out_data",  32'(bus.out_data), 0);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_count",     32'(bus.cycle_count), 0);
    check("rst_ready",     32'(bus.load_ready), 1);
    check("rst_running",   32'(bus.running), 0);
    check("rst_halted",    32'(bus.halted), 0);
    rst = 1'b1;

    load(6'd0, 6'h15);
    load(6'd1, 6'h3B);
    load(6'd2, 6'h0F);

    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    check("idle_stop_running", 32'(bus.running), 0);

    // free run: OUT every 4 clk, then stop during an EXEC
    bus.start = 1'b1;
    for (int k = 1; k <= 21; k++) begin
      tick();
      if (k == 1) bus.start = 1'b0;
      if (k == 21) bus.stop = 1'b0;
      exp_clk = (k == 1) ? 0 : (k == 2) ? 1 : (k % 2);
      exp_rst = (k <= 2) ? 1 : 0;
      exp_run = (k >= 3) ? 1 : 0;
      exp_ov  = (k >= 7 && ((k - 7) % 4) == 0) ? 1 : 0;
      exp_cnt = (k < 5) ? 0 : (k - 3) / 2;
      check("run_cpu_clk", 32'(bus.cpu_clk), exp_clk);
      check("run_cpu_rst", 32'(bus.cpu_rst), exp_rst);
      check("run_running", 32'(bus.running), exp_run);
      check("run_out_valid", 32'(bus.out_valid), exp_ov);
      check("run_count", 32'(bus.cycle_count), exp_cnt);
      if (exp_ov == 1) check("run_out_data", 32'(bus.out_data), 32'h05);
      if (k >= 4) begin
        e = k - (k % 2);
        exp_inst = (e == 4) ? 32'h15 : ((e % 4) == 2) ? 32'h3B : 32'h0F;
        check("run_cpu_inst", 32'(bus.cpu_inst), exp_inst);
      end
      if (k == 20) bus.stop = 1'b1;
    end
    tick();
    check("stop_halted",  32'(bus.halted), 1);
    check("stop_cpu_clk", 32'(bus.cpu_clk), 1);
    check("stop_running", 32'(bus.running), 0);
    check("stop_ready",   32'(bus.load_ready), 1);
    check("stop_count",   32'(bus.cycle_count), 9);

    // patch program while halted at PC 1: LDI 7, OUT, BCC -2
    load(6'd1, 6'h17);
    load(6'd2, 6'h3B);
    load(6'd3, 6'h0E);
    pulse_start();
    tick();
    check("patch_inst", 32'(bus.cpu_inst), 32'h17);
    check("patch_cpu_clk", 32'(bus.cpu_clk), 0);
    wait_out(10, n);
    check("patch_out_latency", 32'(n), 3);
    check("patch_out_data", 32'(bus.out_data), 32'h07);
    check("patch_count", 32'(bus.cycle_count), 11);

    // writes while running must be dropped
    bus.load_valid = 1'b1;
    bus.load_addr  = 6'd2;
    bus.load_data  = 6'h15;
    check("busy_ready", 32'(bus.load_ready), 0);
    repeat (4) tick();
    bus.load_valid = 1'b0;
    wait_out(12, n);
    check("busy_out_latency", 32'(n), 2);
    check("busy_out_data", 32'(bus.out_data), 32'h07);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    run_to_halt(10, n, o, last);
    check("busy_halt_cycles", 32'(n), 2);
    pulse_start();
    wait_out(12, n);
    check("rerun_out_latency", 32'(n), 4);
    check("rerun_out_data", 32'(bus.out_data), 32'h07);

    // reset during an OUT execute phase
    repeat (5) tick();
    check("pre_rst_inst", 32'(bus.cpu_inst), 32'h3B);
    check("pre_rst_cpu_clk", 32'(bus.cpu_clk), 0);
    rst = 1'b0;
    tick();
    check("midrst_out_valid", 32'(bus.out_valid), 0);
    check("midrst_cpu_rst",   32'(bus.cpu_rst), 1);
    check("midrst_cpu_clk",   32'(bus.cpu_clk), 0);
    check("midrst_count",     32'(bus.cycle_count), 0);
    check("midrst_running",   32'(bus.running), 0);
    check("midrst_ready",     32'(bus.load_ready), 1);
    check("midrst_cpu_inst",  32'(bus.cpu_inst), 0);
    rst = 1'b1;

    // breakpoint at PC 1 on the original program
    load(6'd1, 6'h3B);
    load(6'd2, 6'h0F);
    bus.bp_en   = 1'b1;
    bus.bp_addr = 8'h01;
    pulse_start();
    run_to_halt(20, n, o, last);
    check("bp_cycles", 32'(n), 5);
    check("bp_outs", 32'(o), 0);
    check("bp_count", 32'(bus.cycle_count), 1);
    pulse_start();
    run_to_halt(20, n, o, last);
    check("bp_resume_cycles", 32'(n), 5);
    check("bp_resume_outs", 32'(o), 1);
    check("bp_resume_data", 32'(last), 32'h05);
    check("bp_resume_count", 32'(bus.cycle_count), 3);

    pulse_step();
    run_to_halt(20, n, o, last);
    check("step1_cycles", 32'(n), 3);
    check("step1_outs", 32'(o), 1);
    check("step1_count", 32'(bus.cycle_count), 4);
    pulse_step();
    run_to_halt(20, n, o, last);
    check("step2_cycles", 32'(n), 3);
    check("step2_outs", 32'(o), 0);
    check("step2_count", 32'(bus.cycle_count), 5);

    // 4-bit counter saturates; start while running is ignored
    bus.bp_en = 1'b0;
    pulse_start();
    repeat (10) tick();
    pulse_start();
    check("run_start_ignored", 32'(bus.running), 1);
    repeat (30) tick();
    check("sat_count", 32'(bus.cycle_count), 32'hF);
    check("sat_running", 32'(bus.running), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mcpu5_sequencer.md
Name: mcpu5_sequencer

Overview:
- Drives one MCPU5plus core from a single fast system clock.
- Generates the core's half-rate clock and reset.
- Holds the program in a small local RAM and feeds instructions by sampling the PC/accu multiplexed bus.
- Captures OUT results and gives a host run/stop/step/breakpoint control with program loading.

Parameters:
- PROG_AW, 6, program RAM address width; depth 2**PROG_AW x 6 bits; PC bits above PROG_AW-1 ignored (wrap).
- CNT_W, 16, width of the executed-instruction counter.

Ports:
- clk  in  1  system clock, all logic posedge.
- rst  in  1  synchronous reset, active-low (0 = reset).
- load_valid  in  1  program write strobe.
- load_addr  in  PROG_AW  program write address.
- load_data  in  6  program write data.
- load_ready  out  1  high in IDLE/HALT; writes with load_ready=0 are dropped.
- start  in  1  pulse: IDLE -> reset core and run; HALT -> resume.
- stop  in  1  pulse: halt at next instruction boundary.
- step  in  1  pulse in HALT: execute exactly one instruction.
- bp_en  in  1  breakpoint enable.
- bp_addr  in  8  breakpoint PC.
- cpu_clk  out  1  core clock.
- cpu_rst  out  1  core reset, active-high.
- cpu_inst  out  6  core instruction bus.
- cpu_data  in  8  core output bus: PC while cpu_clk=1, accu while cpu_clk=0.
- out_data  out  8  last OUT value.
- out_valid  out  1  one-cycle pulse per OUT.
- running  out  1  state is FETCH or EXEC.
- halted  out  1  state is HALT.
- cycle_count  out  CNT_W  instructions executed since start from IDLE; saturates at all-ones.

Behaviour:
- All outputs are registered (Moore).
- Reset (rst=0 at posedge): state=IDLE, cpu_clk=0, cpu_rst=1, cpu_inst=0, out_data=0, out_valid=0, cycle_count=0, stop_pend=0, step_pend=0, bp_skip=0. RAM contents are not reset.
- IDLE: cpu_rst=1, cpu_clk=0. start -> RSTA.
- RSTA: cpu_clk=0, cpu_rst=1; clears cycle_count. -> RSTB.
- RSTB: cpu_clk=1, cpu_rst=1. This rising edge resets the core. -> FETCH with cpu_rst=0, cpu_clk=1.
- FETCH (cpu_clk=1, cpu_data=PC), evaluated at end of cycle, in priority order:
  1. stop_pend -> HALT; clear stop_pend.
  2. bp_en && cpu_data==bp_addr && !bp_skip -> HALT. The instruction is not executed.
  3. step_pend already consumed by a completed EXEC -> HALT; clear step_pend.
  4. Otherwise: cpu_inst <= RAM[cpu_data[PROG_AW-1:0]], cpu_clk <= 0, -> EXEC.
- EXEC (cpu_clk=0, cpu_data=accu; the core does STA writes in this phase):
  - If cpu_inst==6'b111011 (OUT): out_data <= cpu_data and out_valid pulses for 1 cycle.
  - cycle_count++ (saturating); bp_skip <= 0; mark step consumed if step_pend.
  - cpu_clk <= 1. The core executes on this edge with cpu_inst stable. -> FETCH.
- cpu_inst changes only on the FETCH->EXEC edge, so it is stable across the whole low phase and the following rising edge.
- One instruction takes 2 clk cycles; OUT appears 1 clk after the fetch of that instruction.
- HALT: cpu_clk held 1, cpu_rst=0, core state preserved, load_ready=1.
  - start -> FETCH with bp_skip=1.
  - step -> FETCH with bp_skip=1, step_pend=1.
  - If start and step arrive together, start wins.
- stop in IDLE/RSTA/RSTB is ignored. In FETCH or EXEC it sets stop_pend (taken at the next FETCH).
- start while running is ignored.
- A load write at an address equal to the address being fetched is impossible: load_ready=0 while running.
- rst mid-run: immediate return to IDLE values. The core is held in reset (cpu_rst=1); its state is re-initialised on the next start.

Test Plan:
- Load RAM[0..2]={0x15 LDI 5, 0x3B OUT, 0x0F BCC -1}, start -> RSTA, RSTB, then FETCH/EXEC alternating. out_valid every 4 clk with out_data=0x05; cpu_inst stable whenever cpu_clk=0.
- Same program, bp_en=1, bp_addr=0x01 -> HALT with cycle_count=1 and no OUT. start -> exactly one OUT (0x05), then halts again at PC 1.
- From HALT, step pulse -> exactly one EXEC. cycle_count increments by 1, then halted=1 again.
- stop pulse during EXEC -> HALT at the following FETCH, cpu_clk=1. Loading new data at address 1 while halted, then start -> new instruction executes.
- load_valid while running -> RAM unchanged (check by later stop and re-run). Asserting rst during EXEC -> next cycle IDLE, cpu_rst=1, out_valid=0, cycle_count=0.
- Force cycle_count near saturation (CNT_W=4 build) -> holds at 0xF after more than 15 instructions.
